// File: rtl/avg_pool_write_sequencer_pkg.sv
// Shared average-pool write constants: opcode range, beats per bank and lane count,
// used by both the write sequencer and the lane-enable write decoder.
package avg_pool_write_sequencer_pkg;

    localparam int unsigned OPC_W              = 6;
    localparam int unsigned AVG_BEATS_PER_BANK = 6;
    localparam int unsigned AVG_LANES          = 16;
    localparam int unsigned AVG_BANK_CNT_W     = 10;

    localparam logic [OPC_W-1:0] OPC_AVG_BASE = 6'd32;
    localparam logic [OPC_W-1:0] OPC_AVG_LAST = 6'd37;
    localparam logic [OPC_W-1:0] OPC_NOP      = 6'd0;

    typedef logic [OPC_W-1:0] avg_opc_t;

endpackage

// File: rtl/avg_pool_write_sequencer.sv
// Sequences average-pool result beats into 16-lane banks, emitting write opcodes
// OPC_BASE..OPC_BASE+5 per bank and handing each full bank downstream.
module avg_pool_write_sequencer
    import avg_pool_write_sequencer_pkg::*;
#(
    parameter logic [OPC_W-1:0] OPC_BASE       = OPC_AVG_BASE,
    parameter int unsigned      BEATS_PER_BANK = AVG_BEATS_PER_BANK,
    parameter int unsigned      BANK_CNT_W     = AVG_BANK_CNT_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [BANK_CNT_W-1:0] i_numBanks,
    input  logic                  i_abort,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [OPC_W-1:0]      o_opcode,
    output logic                  o_bankValid,
    input  logic                  i_bankAck,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int unsigned BEAT_W = $clog2(BEATS_PER_BANK);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t                state;
    logic [BEAT_W-1:0]     beat_cnt;
    logic [BANK_CNT_W-1:0] bank_cnt;
    logic [BANK_CNT_W-1:0] num_banks;

    // Sequencer state and counters; abort outranks every other event.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            beat_cnt  <= '0;
            bank_cnt  <= '0;
            num_banks <= '0;
        end else if (i_abort) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            bank_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        num_banks <= i_numBanks;
                        beat_cnt  <= '0;
                        bank_cnt  <= '0;
                        state     <= (i_numBanks == '0) ? ST_DONE : ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (i_valid) begin
                        if (beat_cnt == BEAT_W'(BEATS_PER_BANK - 1)) begin
                            beat_cnt <= '0;
                            state    <= ST_FLUSH;
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    if (i_bankAck) begin
                        if (bank_cnt == num_banks - BANK_CNT_W'(1)) begin
                            state <= ST_DONE;
                        end else begin
                            bank_cnt <= bank_cnt + BANK_CNT_W'(1);
                            state    <= ST_WRITE;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Opcode is valid in the transfer cycle, so it decodes straight from beat_cnt.
    assign o_ready     = (state == ST_WRITE) && !i_abort;
    assign o_opcode    = o_ready ? (OPC_BASE + OPC_W'(beat_cnt)) : OPC_NOP;
    assign o_bankValid = (state == ST_FLUSH);
    assign o_busy      = (state != ST_IDLE);
    assign o_done      = (state == ST_DONE) && !i_abort;

endmodule

// File: tb/tb_avg_pool_write_sequencer.sv
// Scoreboard bench for avg_pool_write_sequencer: stimulus queues expected opcodes,
// a negedge monitor pops and compares on every beat transfer and bank handshake.
module tb_avg_pool_write_sequencer;

    localparam int unsigned NB_W = 10;
    localparam int unsigned BEATS = 6;
    localparam int unsigned OPC0 = 32;

    logic            clk;
    logic            rst_n;
    logic            i_start;
    logic [NB_W-1:0] i_numBanks;
    logic            i_abort;
    logic            i_valid;
    logic            o_ready;
    logic [5:0]      o_opcode;
    logic            o_bankValid;
    logic            i_bankAck;
    logic            o_busy;
    logic            o_done;

    avg_pool_write_sequencer dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (i_start),
        .i_numBanks  (i_numBanks),
        .i_abort     (i_abort),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_opcode    (o_opcode),
        .o_bankValid (o_bankValid),
        .i_bankAck   (i_bankAck),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int exp_op[$];
    int cur_ack = 0;
    int mon_xfers = 0;
    int mon_banks = 0;
    int mon_dones = 0;
    int bv_run = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every transfer must carry the next queued opcode; handshakes hold length.
    always @(negedge clk) begin
        if (!rst_n) begin
            bv_run = 0;
        end else begin
            if (o_bankValid) bv_run++;
            if (i_valid && o_ready) begin
                mon_xfers++;
                if (exp_op.size() == 0) chk("unexpected_transfer", 1, 0);
                else chk("opcode", int'(o_opcode), exp_op.pop_front());
            end else if (!o_ready) begin
                chk("no_write_opcode", int'(o_opcode), 0);
            end
            if (o_bankValid && i_bankAck) begin
                mon_banks++;
                chk("bank_valid_hold", bv_run, cur_ack + 1);
            end
            if (!o_bankValid || i_bankAck) bv_run = 0;
            if (o_done) mon_dones++;
        end
    end

    function automatic logic pick_valid(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return cyc[0] ? 1'b0 : 1'b1;
            default: return 1'($urandom % 2);
        endcase
    endfunction

    // One full layer: model expects n banks of opcodes 32..37, one done pulse.
    task automatic run_layer(input int n, input int vmode, input int d, input bit noise,
                             output int cycles);
        int x0, b0, d0, bv_cyc, budget;
        bit done;
        x0 = mon_xfers; b0 = mon_banks; d0 = mon_dones;
        cur_ack = d;
        for (int b = 0; b < n; b++)
            for (int k = 0; k < int'(BEATS); k++) exp_op.push_back(int'(OPC0) + k);
        budget = (n + 1) * 200 + 20;
        @(posedge clk); #1;
        i_start = 1'b1; i_numBanks = NB_W'(n); i_valid = pick_valid(vmode, 0);
        cycles = 0; bv_cyc = 0; done = 0;
        while (!done && cycles < budget) begin
            @(posedge clk); #1;
            cycles++;
            if (o_done) begin
                done = 1;
                i_start = 1'b0; i_valid = 1'b0; i_bankAck = 1'b0;
            end else begin
                i_start    = noise ? 1'($urandom % 2) : 1'b0;
                i_numBanks = noise ? NB_W'($urandom) : i_numBanks;
                i_valid    = pick_valid(vmode, cycles);
                bv_cyc     = o_bankValid ? bv_cyc + 1 : 0;
                i_bankAck  = o_bankValid && (bv_cyc == d + 1);
            end
        end
        if (!done) chk("layer_timeout", 0, 1);
        @(posedge clk); #1;
        chk("transfers", mon_xfers - x0, n * int'(BEATS));
        chk("bank_handshakes", mon_banks - b0, n);
        chk("done_pulses", mon_dones - d0, 1);
        chk("queue_drained", exp_op.size(), 0);
        chk("idle_busy", int'(o_busy), 0);
        chk("idle_done", int'(o_done), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ready"}, int'(o_ready), 0);
        chk({tag, "_opcode"}, int'(o_opcode), 0);
        chk({tag, "_bankvalid"}, int'(o_bankValid), 0);
        chk({tag, "_busy"}, int'(o_busy), 0);
        chk({tag, "_done"}, int'(o_done), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, x0, d0;
        rst_n = 1'b0; i_start = 1'b0; i_numBanks = '0; i_abort = 1'b0;
        i_valid = 1'b0; i_bankAck = 1'b0;
        #1;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check_outputs_zero("post_reset");

        // Single bank, continuous valid, ack on third cycle of bankValid.
        run_layer(1, 0, 2, 0, cyc);
        chk("single_bank_cycles", cyc, 1 * (int'(BEATS) + 3) + 1);

        // Backpressure with toggling valid over three banks.
        run_layer(3, 1, int'($urandom_range(0, 3)), 0, cyc);

        // Zero banks goes straight to DONE.
        run_layer(0, 0, 0, 0, cyc);
        chk("zero_bank_cycles", cyc, 1);

        // Abort at beat 4 with valid high: no transfer, back to IDLE, no done.
        x0 = mon_xfers; d0 = mon_dones;
        for (int k = 0; k < 4; k++) exp_op.push_back(int'(OPC0) + k);
        @(posedge clk); #1;
        i_start = 1'b1; i_numBanks = NB_W'(2); i_valid = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        repeat (3) @(posedge clk);
        @(posedge clk); #1;
        i_abort = 1'b1;
        #1;
        chk("abort_ready", int'(o_ready), 0);
        chk("abort_opcode", int'(o_opcode), 0);
        @(posedge clk); #1;
        i_abort = 1'b0; i_valid = 1'b0;
        chk("abort_busy", int'(o_busy), 0);
        @(posedge clk); #1;
        chk("abort_transfers", mon_xfers - x0, 4);
        chk("abort_no_done", mon_dones - d0, 0);
        chk("abort_queue", exp_op.size(), 0);
        run_layer(1, 0, 0, 0, cyc);

        // Start pulses and numBanks changes mid-layer must be ignored.
        run_layer(2, 2, 1, 1, cyc);

        // Reset asserted mid-WRITE with beatCnt=3.
        for (int k = 0; k < 3; k++) exp_op.push_back(int'(OPC0) + k);
        @(posedge clk); #1;
        i_start = 1'b1; i_numBanks = NB_W'(1); i_valid = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check_outputs_zero("mid_reset_release");
        chk("mid_reset_queue", exp_op.size(), 0);

        // Randomized layers.
        for (int t = 0; t < 8; t++)
            run_layer(int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)), bit'($urandom % 2), cyc);

        // Maximum bank count exercises the full counter width.
        run_layer((1 << NB_W) - 1, 0, 0, 0, cyc);
        chk("max_bank_cycles", cyc, ((1 << NB_W) - 1) * (int'(BEATS) + 1) + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
